regbank_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one 8x4 register bank (2 combinational read ports, 1 synchronous write port) among NREQ requesters.
- Serialises each request into a fixed 3-state access, drives the bank address/data/RegWrite pins, and returns read data with a one-cycle done pulse.
- Sits between the requesters (switch front-end, test sequencer, etc.) and the register bank; the display keeps showing the last accessed addresses.

---
 rtl/regbank_arb_pkg.sv | 16 +
 rtl/regbank_arbiter_rr_pick.sv | 38 +++
 rtl/regbank_arbiter.sv | 125 ++++++++++++
 tb/tb_regbank_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/regbank_arb_pkg.sv
// Shared types and defaults for the register-bank arbiter.
//   state_t : sequencer states (IDLE -> ACCESS -> DONE -> IDLE)
//   DEF_AW  : default register address width
//   DEF_DW  : default register data width
package regbank_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int DEF_AW = 3;
  localparam int DEF_DW = 4;

endpackage

// File: rtl/regbank_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req   : request vector, one bit per requester
//   ptr   : index with highest priority this round
//   valid : at least one request is set
//   idx   : first set request found scanning ptr, ptr+1, ... modulo NREQ
module rr_pick #(
  parameter int NREQ = 3,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic            valid,
  output logic [IW-1:0]   idx
);

  // One extra bit so ptr+k never overflows before the explicit wrap,
  // which keeps non-power-of-2 NREQ correct.
  logic [IW:0] pos;

  // Scan from the far end toward ptr so the candidate closest to ptr
  // is written last and wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      pos = {1'b0, ptr} + (IW + 1)'(k);
      if (pos >= (IW + 1)'(NREQ)) begin
        pos = pos - (IW + 1)'(NREQ);
      end
      if (req[pos[IW-1:0]]) begin
        valid = 1'b1;
        idx   = pos[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/regbank_arbiter.sv
// Round-robin arbiter/sequencer sharing one register bank among NREQ
// requesters. Each transaction runs IDLE -> ACCESS -> DONE.
//   clk, rst            : clock, asynchronous active-low reset
//   req, op_wr          : per-requester request level and op (1 = write)
//   addr_a/addr_b/wdata : per-requester operand slices
//   gnt, done, busy     : grant (ACCESS+DONE), done pulse (DONE), busy
//   rdata_a, rdata_b    : read data captured at end of ACCESS, then held
//   bank_*              : register bank address/data/write-enable pins
module regbank_arbiter
  import regbank_arb_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int AW   = DEF_AW,
  parameter int DW   = DEF_DW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  op_wr,
  input  logic [NREQ*AW-1:0] addr_a,
  input  logic [NREQ*AW-1:0] addr_b,
  input  logic [NREQ*DW-1:0] wdata,
  output logic [NREQ-1:0]  gnt,
  output logic [NREQ-1:0]  done,
  output logic [DW-1:0]    rdata_a,
  output logic [DW-1:0]    rdata_b,
  output logic             busy,
  output logic [AW-1:0]    bank_addrRa,
  output logic [AW-1:0]    bank_addrRb,
  output logic [AW-1:0]    bank_addrW,
  output logic [DW-1:0]    bank_datW,
  output logic             bank_RegWrite,
  input  logic [DW-1:0]    bank_datOutRa,
  input  logic [DW-1:0]    bank_datOutRb
);

  localparam int IW = $clog2(NREQ);

  state_t          state, state_nxt;
  logic [IW-1:0]   ptr;
  logic            pick_valid;
  logic [IW-1:0]   pick_idx;

  logic [IW-1:0]   idx_p0;
  logic            wr_p0;
  logic [AW-1:0]   addr_a_p0;
  logic [AW-1:0]   addr_b_p0;
  logic [DW-1:0]   wdata_p0;
  logic [DW-1:0]   rdata_a_p1;
  logic [DW-1:0]   rdata_b_p1;
  logic [NREQ-1:0] sel;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req   (req),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (pick_valid) state_nxt = ACCESS;
      ACCESS:  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: arbitration result and operands latched in IDLE.
  // Stage p1: bank read data captured at the end of a read ACCESS.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      ptr        <= '0;
      idx_p0     <= '0;
      wr_p0      <= 1'b0;
      addr_a_p0  <= '0;
      addr_b_p0  <= '0;
      wdata_p0   <= '0;
      rdata_a_p1 <= '0;
      rdata_b_p1 <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          if (pick_valid) begin
            idx_p0    <= pick_idx;
            wr_p0     <= op_wr[pick_idx];
            addr_a_p0 <= addr_a[pick_idx*AW +: AW];
            addr_b_p0 <= addr_b[pick_idx*AW +: AW];
            wdata_p0  <= wdata[pick_idx*DW +: DW];
          end
        end
        ACCESS: begin
          if (!wr_p0) begin
            rdata_a_p1 <= bank_datOutRa;
            rdata_b_p1 <= bank_datOutRb;
          end
        end
        DONE: begin
          ptr <= (idx_p0 == IW'(NREQ - 1)) ? '0 : idx_p0 + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    sel         = '0;
    sel[idx_p0] = 1'b1;
  end

  assign busy          = (state != IDLE);
  assign gnt           = busy ? sel : '0;
  assign done          = (state == DONE) ? sel : '0;
  assign bank_RegWrite = (state == ACCESS) && wr_p0;
  assign bank_addrRa   = addr_a_p0;
  assign bank_addrW    = addr_a_p0;
  assign bank_addrRb   = addr_b_p0;
  assign bank_datW     = wdata_p0;
  assign rdata_a       = rdata_a_p1;
  assign rdata_b       = rdata_b_p1;

endmodule

// File: tb/tb_regbank_arbiter.sv
module tb_regbank_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req;
  logic [2:0]  op_wr;
  logic [8:0]  addr_a;
  logic [8:0]  addr_b;
  logic [11:0] wdata;
  logic [2:0]  gnt;
  logic [2:0]  done;
  logic [3:0]  rdata_a;
  logic [3:0]  rdata_b;
  logic        busy;
  logic [2:0]  bank_addrRa;
  logic [2:0]  bank_addrRb;
  logic [2:0]  bank_addrW;
  logic [3:0]  bank_datW;
  logic        bank_RegWrite;
  logic [3:0]  bank_datOutRa;
  logic [3:0]  bank_datOutRb;

  always #5 clk = ~clk;

  regbank_arbiter #(.NREQ(3), .AW(3), .DW(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .op_wr         (op_wr),
    .addr_a        (addr_a),
    .addr_b        (addr_b),
    .wdata         (wdata),
    .gnt           (gnt),
    .done          (done),
    .rdata_a       (rdata_a),
    .rdata_b       (rdata_b),
    .busy          (busy),
    .bank_addrRa   (bank_addrRa),
    .bank_addrRb   (bank_addrRb),
    .bank_addrW    (bank_addrW),
    .bank_datW     (bank_datW),
    .bank_RegWrite (bank_RegWrite),
    .bank_datOutRa (bank_datOutRa),
    .bank_datOutRb (bank_datOutRb)
  );

  // Register bank model: 8x4, combinational reads, synchronous write.
  logic [3:0] mem [8];
  initial for (int i = 0; i < 8; i++) mem[i] = 4'h0;
  always @(posedge clk) if (bank_RegWrite) mem[bank_addrW] <= bank_datW;
  assign bank_datOutRa = mem[bank_addrRa];
  assign bank_datOutRb = mem[bank_addrRb];

  typedef struct {
    logic [2:0] d;
    logic [3:0] ra;
    logic [3:0] rb;
    logic       chk_data;
  } sb_t;

  sb_t sb[$];
  int  ncmp  = 0;
  int  nfail = 0;
  int  cyc   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [2:0] d, input logic [3:0] ra, input logic [3:0] rb,
                      input logic chk_data);
    sb_t e;
    e.d = d; e.ra = ra; e.rb = rb; e.chk_data = chk_data;
    sb.push_back(e);
  endtask

  // Advance one clock, sample 1 time unit after the edge and retire any done.
  task automatic tick();
    sb_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (done !== 3'b000) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", {29'd0, done}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("done", {29'd0, done}, {29'd0, e.d});
        if (e.chk_data) begin
          chk("rdata_a", {28'd0, rdata_a}, {28'd0, e.ra});
          chk("rdata_b", {28'd0, rdata_b}, {28'd0, e.rb});
        end
      end
    end
  endtask

  task automatic set_req(input int i, input logic wr, input logic [2:0] a,
                         input logic [2:0] b, input logic [3:0] d);
    op_wr[i]          = wr;
    addr_a[i*3 +: 3]  = a;
    addr_b[i*3 +: 3]  = b;
    wdata[i*4 +: 4]   = d;
  endtask

  initial begin
    int nd;
    int last;

    // Reset with all requests high
    rst = 1'b0; req = 3'b111; op_wr = 3'b000;
    addr_a = '0; addr_b = '0; wdata = '0;
    tick(); tick();
    chk("rst_gnt", {29'd0, gnt}, 32'd0);
    chk("rst_done", {29'd0, done}, 32'd0);
    chk("rst_regwrite", {31'd0, bank_RegWrite}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rdata_a", {28'd0, rdata_a}, 32'd0);
    req = 3'b000; rst = 1'b1;
    tick();
    chk("post_rst_busy", {31'd0, busy}, 32'd0);

    // Single write by requester 0: reg5 <= A
    set_req(0, 1'b1, 3'd5, 3'd0, 4'hA);
    req = 3'b001;
    push(3'b001, 4'h0, 4'h0, 1'b0);
    tick();
    chk("wr_gnt", {29'd0, gnt}, 32'd1);
    chk("wr_busy", {31'd0, busy}, 32'd1);
    chk("wr_regwrite", {31'd0, bank_RegWrite}, 32'd1);
    chk("wr_addrW", {29'd0, bank_addrW}, 32'd5);
    chk("wr_datW", {28'd0, bank_datW}, 32'hA);
    tick();
    chk("wr_regwrite_once", {31'd0, bank_RegWrite}, 32'd0);
    chk("wr_gnt_done", {29'd0, gnt}, 32'd1);
    req = 3'b000;
    tick();
    chk("wr_idle_busy", {31'd0, busy}, 32'd0);
    chk("wr_idle_done", {29'd0, done}, 32'd0);
    chk("wr_idle_addrW", {29'd0, bank_addrW}, 32'd5);

    // Read-back by requester 1: reg5, reg0
    set_req(1, 1'b0, 3'd5, 3'd0, 4'h0);
    req = 3'b010;
    push(3'b010, 4'hA, 4'h0, 1'b1);
    tick();
    chk("rd_gnt", {29'd0, gnt}, 32'd2);
    chk("rd_regwrite", {31'd0, bank_RegWrite}, 32'd0);
    chk("rd_addrRb", {29'd0, bank_addrRb}, 32'd0);
    tick();
    req = 3'b000;
    tick();
    chk("rd_hold_a", {28'd0, rdata_a}, 32'hA);

    // Requester 2 writes reg3 <= 7 (pointer then wraps to 0)
    set_req(2, 1'b1, 3'd3, 3'd0, 4'h7);
    req = 3'b100;
    push(3'b100, 4'h0, 4'h0, 1'b0);
    tick(); tick();
    req = 3'b000;
    tick();

    // Contention: all three read, grant order 0,1,2,0,1, done every 3 cycles
    set_req(0, 1'b0, 3'd5, 3'd5, 4'h0);
    set_req(1, 1'b0, 3'd0, 3'd3, 4'h0);
    set_req(2, 1'b0, 3'd3, 3'd5, 4'h0);
    push(3'b001, 4'hA, 4'hA, 1'b1);
    push(3'b010, 4'h0, 4'h7, 1'b1);
    push(3'b100, 4'h7, 4'hA, 1'b1);
    push(3'b001, 4'hA, 4'hA, 1'b1);
    push(3'b010, 4'h0, 4'h7, 1'b1);
    req = 3'b111;
    nd = 0;
    last = 0;
    for (int t = 0; t < 20 && nd < 5; t++) begin
      tick();
      if (done !== 3'b000) begin
        if (nd > 0) chk("done_gap", 32'(cyc - last), 32'd3);
        last = cyc;
        nd++;
        if (nd == 5) req = 3'b000;
      end
    end
    chk("contention_count", 32'(nd), 32'd5);
    tick();

    // Wrap/skip: ptr=2, req=011 -> grant 0
    req = 3'b011;
    push(3'b001, 4'hA, 4'hA, 1'b1);
    tick();
    chk("wrap_gnt", {29'd0, gnt}, 32'd1);
    tick();
    req = 3'b000;
    tick();

    // Reset during a write ACCESS (requester 1: reg6 <= F)
    set_req(1, 1'b1, 3'd6, 3'd0, 4'hF);
    req = 3'b010;
    tick();
    chk("rw_gnt", {29'd0, gnt}, 32'd2);
    chk("rw_regwrite_pre", {31'd0, bank_RegWrite}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("rw_regwrite_drop", {31'd0, bank_RegWrite}, 32'd0);
    chk("rw_gnt_drop", {29'd0, gnt}, 32'd0);
    chk("rw_busy_drop", {31'd0, busy}, 32'd0);
    chk("rw_addrW_clr", {29'd0, bank_addrW}, 32'd0);
    chk("rw_rdata_clr", {28'd0, rdata_b}, 32'd0);
    req = 3'b000;
    tick();
    chk("rw_no_done", {29'd0, done}, 32'd0);
    rst = 1'b1;
    tick();

    // Post-reset: ptr=0 so req=101 grants 0; reg6 unchanged, reg3 still 7
    set_req(0, 1'b0, 3'd6, 3'd3, 4'h0);
    set_req(2, 1'b0, 3'd5, 3'd5, 4'h0);
    req = 3'b101;
    push(3'b001, 4'h0, 4'h7, 1'b1);
    tick();
    chk("post_gnt", {29'd0, gnt}, 32'd1);
    tick();
    req = 3'b000;
    tick();
    tick();

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
